// File: rtl/pcm56_pkg.sv
// Shared definitions for the PCM56 transmit path.
//   state_t  : frame sequencer states (IDLE, CONV, SHIFT, LATCH)
//   OUT_W    : PCM56 word width
//   SAT_POS / SAT_NEG : clamp values for positive / negative overflow
package pcm56_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int unsigned OUT_W = 16;

  localparam logic [OUT_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [OUT_W-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/pcm56_round_sat.sv
// Combinational narrowing of one signed sample to the DAC word width.
//   sample : IN_W-bit signed input
//   word   : OUT_W-bit signed result (rounded half-up when ROUND=1, else truncated)
//   clip   : high when the result had to be clamped to positive/negative full scale
module pcm56_round_sat #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned ROUND = 1
) (
  input  logic [IN_W-1:0]  sample,
  output logic [OUT_W-1:0] word,
  output logic             clip
);

  localparam int unsigned DROP = IN_W - OUT_W;
  localparam logic [IN_W:0] HALF =
    (ROUND != 0) ? ((IN_W+1)'(1) << (DROP - 1)) : '0;
  localparam logic [OUT_W-1:0] POS_FS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_FS = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W:0] ext;
  logic [IN_W:0] sum;
  logic          unused_low;

  always_comb begin
    ext        = {sample[IN_W-1], sample};
    sum        = ext + HALF;
    unused_low = ^sum[DROP-1:0];
    // The extra sign bit disagrees with the kept MSB only on overflow;
    // the extra bit then carries the true sign and selects the clamp.
    clip = (sum[IN_W] != sum[IN_W-1]);
    if (!clip) begin
      word = sum[IN_W-1 -: OUT_W];
    end else if (sum[IN_W]) begin
      word = NEG_FS;
    end else begin
      word = POS_FS;
    end
  end

endmodule

// File: rtl/pcm56_tx.sv
// PCM56 DAC transmitter: accepts one stereo sample per valid/ready handshake,
// narrows each channel to OUT_W bits and shifts both words MSB-first on a shared
// bit clock, then pulses LE low so its falling edge latches the words.
//   mck_i               : clock, all logic on the rising edge
//   rst_i               : synchronous active-low reset
//   s_valid_i/s_ready_o : input handshake (ready only while idle)
//   s_left_i/s_right_i  : IN_W-bit signed samples
//   bck_o               : DAC bit clock, data sampled by the DAC on its rising edge
//   sdo_l_o/sdo_r_o     : serial data to the left/right DAC
//   le_o                : latch enable, falling edge latches the word
//   busy_o              : high in every state except IDLE
//   clip_o              : one-cycle pulse when either channel saturated
module pcm56_tx #(
  parameter int unsigned IN_W        = 24,
  parameter int unsigned OUT_W       = pcm56_pkg::OUT_W,
  parameter int unsigned BCK_HALF    = 2,
  parameter int unsigned LE_LOW_BITS = 2,
  parameter int unsigned ROUND       = 1
) (
  input  logic            mck_i,
  input  logic            rst_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic [IN_W-1:0] s_left_i,
  input  logic [IN_W-1:0] s_right_i,
  output logic            bck_o,
  output logic            sdo_l_o,
  output logic            sdo_r_o,
  output logic            le_o,
  output logic            busy_o,
  output logic            clip_o
);

  import pcm56_pkg::*;

  localparam int unsigned LATCH_CYC = LE_LOW_BITS * 2 * BCK_HALF;
  localparam int unsigned DIV_W     = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int unsigned BIT_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned LAT_W     = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OUT_W - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [OUT_W-1:0] sr_l;
  logic [OUT_W-1:0] sr_r;
  logic [OUT_W-1:0] word_l;
  logic [OUT_W-1:0] word_r;
  logic             clip_l;
  logic             clip_r;

  pcm56_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ROUND (ROUND)
  ) u_rs_l (
    .sample (s_left_i),
    .word   (word_l),
    .clip   (clip_l)
  );

  pcm56_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ROUND (ROUND)
  ) u_rs_r (
    .sample (s_right_i),
    .word   (word_r),
    .clip   (clip_r)
  );

  always_ff @(posedge mck_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      bck_o     <= 1'b0;
      sdo_l_o   <= 1'b0;
      sdo_r_o   <= 1'b0;
      le_o      <= 1'b1;
      s_ready_o <= 1'b0;
      busy_o    <= 1'b0;
      clip_o    <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
      sr_l      <= '0;
      sr_r      <= '0;
    end else begin
      clip_o <= 1'b0;
      unique case (state)
        IDLE: begin
          le_o  <= 1'b1;
          bck_o <= 1'b0;
          if (s_ready_o && s_valid_i) begin
            // Narrowing happens on the accept edge so the words and the
            // clip pulse are both registered by the time CONV is active.
            sr_l      <= word_l;
            sr_r      <= word_r;
            clip_o    <= clip_l | clip_r;
            s_ready_o <= 1'b0;
            busy_o    <= 1'b1;
            state     <= CONV;
          end else begin
            s_ready_o <= 1'b1;
          end
        end

        CONV: begin
          sdo_l_o <= sr_l[OUT_W-1];
          sdo_r_o <= sr_r[OUT_W-1];
          sr_l    <= {sr_l[OUT_W-2:0], 1'b0};
          sr_r    <= {sr_r[OUT_W-2:0], 1'b0};
          bck_o   <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!bck_o) begin
              bck_o <= 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
              bck_o   <= 1'b0;
              sdo_l_o <= 1'b0;
              sdo_r_o <= 1'b0;
              le_o    <= 1'b0;
              lat_cnt <= '0;
              state   <= LATCH;
            end else begin
              // New bit only on the falling bck edge.
              bck_o   <= 1'b0;
              bit_cnt <= bit_cnt + BIT_W'(1);
              sdo_l_o <= sr_l[OUT_W-1];
              sdo_r_o <= sr_r[OUT_W-1];
              sr_l    <= {sr_l[OUT_W-2:0], 1'b0};
              sr_r    <= {sr_r[OUT_W-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        LATCH: begin
          if (lat_cnt == LAT_LAST) begin
            // Ready rises together with LE so a new sample is taken on the
            // very next edge.
            le_o      <= 1'b1;
            s_ready_o <= 1'b1;
            busy_o    <= 1'b0;
            state     <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm56_tx.sv
// Self-checking bench for pcm56_tx: three instances (defaults, truncating,
// fast bit clock) driven with directed and random samples; received words are
// reassembled from the serial lines and compared with an arithmetic model.
module tb_pcm56_tx;

  import pcm56_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] valid;
  logic [23:0]  in_l [N];
  logic [23:0]  in_r [N];
  logic [N-1:0] ready, bck, sdo_l, sdo_r, le, busy, clip;

  int checks = 0;
  int errors = 0;

  // Results collected by run_stream
  logic [23:0] src_l[$];
  logic [23:0] src_r[$];
  int          acc_c[$];
  logic [15:0] got_l[$];
  logic [15:0] got_r[$];
  int          rises[$];
  int          le_low[$];
  int          clip_c[$];
  int          viol;
  int          end_c;
  bit          timed_out;

  pcm56_tx #(.IN_W(24), .OUT_W(16), .BCK_HALF(2), .LE_LOW_BITS(2), .ROUND(1)) u_def (
    .mck_i(clk), .rst_i(rst_n), .s_valid_i(valid[0]), .s_ready_o(ready[0]),
    .s_left_i(in_l[0]), .s_right_i(in_r[0]), .bck_o(bck[0]), .sdo_l_o(sdo_l[0]),
    .sdo_r_o(sdo_r[0]), .le_o(le[0]), .busy_o(busy[0]), .clip_o(clip[0]));

  pcm56_tx #(.IN_W(24), .OUT_W(16), .BCK_HALF(2), .LE_LOW_BITS(2), .ROUND(0)) u_trunc (
    .mck_i(clk), .rst_i(rst_n), .s_valid_i(valid[1]), .s_ready_o(ready[1]),
    .s_left_i(in_l[1]), .s_right_i(in_r[1]), .bck_o(bck[1]), .sdo_l_o(sdo_l[1]),
    .sdo_r_o(sdo_r[1]), .le_o(le[1]), .busy_o(busy[1]), .clip_o(clip[1]));

  pcm56_tx #(.IN_W(24), .OUT_W(16), .BCK_HALF(1), .LE_LOW_BITS(1), .ROUND(1)) u_fast (
    .mck_i(clk), .rst_i(rst_n), .s_valid_i(valid[2]), .s_ready_o(ready[2]),
    .s_left_i(in_l[2]), .s_right_i(in_r[2]), .bck_o(bck[2]), .sdo_l_o(sdo_l[2]),
    .sdo_r_o(sdo_r[2]), .le_o(le[2]), .busy_o(busy[2]), .clip_o(clip[2]));

  function automatic int bh_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int lb_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int rnd_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic int frame_len(input int d);
    return 1 + 16 * 2 * bh_of(d) + lb_of(d) * 2 * bh_of(d);
  endfunction

  // {clip, word}: scale by 1/256 with floor, optional +0.5 LSB, clamp to 16-bit range
  function automatic logic [16:0] model(input logic [23:0] s, input int rnd);
    int v;
    v = int'($signed(s));
    if (rnd != 0) v = v + 128;
    v = v >>> 8;
    if (v > 32767)  return {1'b1, SAT_POS};
    if (v < -32768) return {1'b1, SAT_NEG};
    return {1'b0, v[15:0]};
  endfunction

  function automatic logic [23:0] pick_sample();
    logic [23:0] edges [6];
    edges[0] = 24'h7FFFFF; edges[1] = 24'h800000; edges[2] = 24'h7FFF80;
    edges[3] = 24'h7FFF7F; edges[4] = 24'hFFFF80; edges[5] = 24'hFFFF7F;
    if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 5)];
    return 24'($urandom);
  endfunction

  // Feeds src_l/src_r to instance d, holding valid high while samples remain,
  // and decodes the serial stream until the instance is idle again.
  task automatic run_stream(input int d, input int budget);
    int idx, c, nr, nlow;
    logic pv, pr, pb, ple, psl, psr;
    logic [15:0] cl, cr;
    acc_c.delete(); got_l.delete(); got_r.delete(); rises.delete();
    le_low.delete(); clip_c.delete();
    viol = 0; timed_out = 0; end_c = 0;
    idx = 0; c = 0; nr = 0; nlow = 0;
    pv = 0; pr = 0; pb = 0; ple = 1; psl = 0; psr = 0; cl = '0; cr = '0;
    forever begin
      @(negedge clk);
      if (pv && pr) begin
        acc_c.push_back(c);
        idx++;
      end
      if (bck[d] && !pb) begin
        cl = {cl[14:0], sdo_l[d]};
        cr = {cr[14:0], sdo_r[d]};
        nr++;
      end
      if (bck[d] && pb && (sdo_l[d] !== psl || sdo_r[d] !== psr)) viol++;
      if (!le[d]) begin
        nlow++;
        if (bck[d] !== 1'b0 || sdo_l[d] !== 1'b0 || sdo_r[d] !== 1'b0) viol++;
      end
      if (ple && !le[d]) begin
        got_l.push_back(cl);
        got_r.push_back(cr);
        rises.push_back(nr);
        nr = 0;
      end
      if (!ple && le[d]) begin
        le_low.push_back(nlow);
        nlow = 0;
      end
      if (clip[d]) clip_c.push_back(c);
      if (idx >= src_l.size() && ready[d]) begin
        end_c = c;
        break;
      end
      if (c >= budget) begin
        timed_out = 1;
        break;
      end
      if (idx < src_l.size()) begin
        valid[d] = 1'b1;
        in_l[d]  = src_l[idx];
        in_r[d]  = src_r[idx];
      end else begin
        valid[d] = 1'b0;
      end
      pv = valid[d]; pr = ready[d]; pb = bck[d]; ple = le[d];
      psl = sdo_l[d]; psr = sdo_r[d];
      c++;
    end
    valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      valid[d] = 1'b1; in_l[d] = 24'h123456; in_r[d] = 24'h654321;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", ready); end
      checks++; if (le !== 3'b111) begin errors++; $display("FAIL reset_le: got %b expected 111", le); end
      checks++; if (bck !== 3'b000) begin errors++; $display("FAIL reset_bck: got %b expected 000", bck); end
      checks++; if ((sdo_l | sdo_r) !== 3'b000) begin errors++; $display("FAIL reset_sdo: got %b/%b expected 000", sdo_l, sdo_r); end
      checks++; if ((busy | clip) !== 3'b000) begin errors++; $display("FAIL reset_busy_clip: got %b/%b expected 000", busy, clip); end
    end
    rst_n = 1'b1;
    valid = '0;
    @(negedge clk);
    checks++; if (ready !== 3'b111) begin errors++; $display("FAIL reset_release_ready: got %b expected 111", ready); end
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_release_busy: got %b expected 000", busy); end
  endtask

  task automatic test_basic();
    src_l = '{24'h123456}; src_r = '{24'hFEDCBA};
    run_stream(0, 200);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout expected completion"); end
    checks++;
    if (got_l.size() != 1) begin
      errors++; $display("FAIL basic_words: got %0d words expected 1", got_l.size());
    end else begin
      checks++; if (got_l[0] !== 16'h1234) begin errors++; $display("FAIL basic_left: got %h expected 1234", got_l[0]); end
      checks++; if (got_r[0] !== 16'hFEDD) begin errors++; $display("FAIL basic_right: got %h expected fedd", got_r[0]); end
      checks++; if (rises[0] != 16) begin errors++; $display("FAIL basic_rises: got %0d expected 16", rises[0]); end
    end
    checks++;
    if (le_low.size() != 1 || le_low[0] != 8) begin
      errors++; $display("FAIL basic_le_low: got %0d frames/%0d cycles expected 1/8", le_low.size(), (le_low.size() > 0) ? le_low[0] : -1);
    end
    checks++;
    if (acc_c.size() != 1 || end_c - acc_c[0] != 73) begin
      errors++; $display("FAIL basic_latency: got %0d expected 73 (next accept 74)", (acc_c.size() > 0) ? end_c - acc_c[0] : -1);
    end
    checks++; if (clip_c.size() != 0) begin errors++; $display("FAIL basic_clip: got %0d pulses expected 0", clip_c.size()); end
    checks++; if (viol != 0) begin errors++; $display("FAIL basic_timing: got %0d violations expected 0", viol); end
  endtask

  task automatic test_saturation();
    for (int d = 0; d < 2; d++) begin
      src_l = '{24'h7FFFC0}; src_r = '{24'h800000};
      run_stream(d, 200);
      checks++;
      if (timed_out || got_l.size() != 1) begin
        errors++; $display("FAIL sat_words_d%0d: got %0d words expected 1", d, got_l.size());
      end else begin
        checks++; if (got_l[0] !== SAT_POS) begin errors++; $display("FAIL sat_left_d%0d: got %h expected %h", d, got_l[0], SAT_POS); end
        checks++; if (got_r[0] !== SAT_NEG) begin errors++; $display("FAIL sat_right_d%0d: got %h expected %h", d, got_r[0], SAT_NEG); end
      end
      checks++;
      if (d == 0) begin
        if (clip_c.size() != 1 || acc_c.size() != 1 || clip_c[0] != acc_c[0]) begin
          errors++; $display("FAIL sat_clip_d0: got %0d pulses expected 1 in CONV", clip_c.size());
        end
      end else if (clip_c.size() != 0) begin
        errors++; $display("FAIL sat_clip_d1: got %0d pulses expected 0", clip_c.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] el, er;
    src_l.delete(); src_r.delete();
    for (int i = 0; i < 3; i++) begin
      src_l.push_back(pick_sample()); src_r.push_back(pick_sample());
    end
    run_stream(0, 400);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got timeout expected completion"); end
    checks++;
    if (acc_c.size() != 3 || got_l.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d accepts/%0d latches expected 3/3", acc_c.size(), got_l.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_c[i] - acc_c[i-1] != 74) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d expected 74", i, acc_c[i] - acc_c[i-1]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        el = model(src_l[i], 1); er = model(src_r[i], 1);
        checks++;
        if (got_l[i] !== el[15:0] || got_r[i] !== er[15:0]) begin
          errors++; $display("FAIL b2b_word%0d: got %h/%h expected %h/%h", i, got_l[i], got_r[i], el[15:0], er[15:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int nr, falls;
    logic pb, ple;
    logic [16:0] el, er;
    @(negedge clk);
    valid[0] = 1'b1; in_l[0] = 24'h5A5A5A; in_r[0] = 24'hA5A5A5;
    @(negedge clk);
    valid[0] = 1'b0;
    nr = 0; falls = 0; pb = bck[0]; ple = le[0];
    for (int c = 0; c < 200 && nr < 7; c++) begin
      @(negedge clk);
      if (bck[0] && !pb) nr++;
      if (ple && !le[0]) falls++;
      pb = bck[0]; ple = le[0];
    end
    checks++; if (nr != 7) begin errors++; $display("FAIL midrst_bits: got %0d rises expected 7", nr); end
    rst_n = 1'b0;
    @(negedge clk);
    if (ple && !le[0]) falls++;
    checks++; if (falls != 0) begin errors++; $display("FAIL midrst_le_fall: got %0d expected 0", falls); end
    checks++;
    if (le[0] !== 1'b1 || bck[0] !== 1'b0 || sdo_l[0] !== 1'b0 || sdo_r[0] !== 1'b0 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got le=%b bck=%b sdo=%b%b busy=%b ready=%b expected 1 0 00 0 0",
                         le[0], bck[0], sdo_l[0], sdo_r[0], busy[0], ready[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready[0]); end
    src_l = '{24'hC3C3C3}; src_r = '{24'h3C3C3C};
    run_stream(0, 200);
    el = model(24'hC3C3C3, 1); er = model(24'h3C3C3C, 1);
    checks++;
    if (timed_out || got_l.size() != 1) begin
      errors++; $display("FAIL midrst_next_count: got %0d latches expected 1", got_l.size());
    end else if (got_l[0] !== el[15:0] || got_r[0] !== er[15:0] || rises[0] != 16) begin
      errors++; $display("FAIL midrst_next_word: got %h/%h (%0d bits) expected %h/%h (16 bits)",
                         got_l[0], got_r[0], rises[0], el[15:0], er[15:0]);
    end
  endtask

  task automatic test_fast();
    logic [16:0] er;
    src_l = '{24'h000080}; src_r = '{24'($urandom)};
    er = model(src_r[0], 1);
    run_stream(2, 100);
    checks++;
    if (timed_out || got_l.size() != 1) begin
      errors++; $display("FAIL fast_count: got %0d latches expected 1", got_l.size());
    end else begin
      checks++; if (got_l[0] !== 16'h0001) begin errors++; $display("FAIL fast_left: got %h expected 0001", got_l[0]); end
      checks++; if (got_r[0] !== er[15:0]) begin errors++; $display("FAIL fast_right: got %h expected %h", got_r[0], er[15:0]); end
    end
    checks++;
    if (acc_c.size() != 1 || end_c - acc_c[0] != 35) begin
      errors++; $display("FAIL fast_latency: got %0d expected 35 (next accept 36)", (acc_c.size() > 0) ? end_c - acc_c[0] : -1);
    end
    checks++;
    if (le_low.size() != 1 || le_low[0] != 2) begin
      errors++; $display("FAIL fast_le_low: got %0d cycles expected 2", (le_low.size() > 0) ? le_low[0] : -1);
    end
  endtask

  task automatic test_random();
    logic [16:0] el, er;
    int nclip, f;
    for (int d = 0; d < N; d++) begin
      src_l.delete(); src_r.delete();
      nclip = 0;
      f = frame_len(d);
      for (int i = 0; i < 5; i++) begin
        src_l.push_back(pick_sample()); src_r.push_back(pick_sample());
        el = model(src_l[i], rnd_of(d)); er = model(src_r[i], rnd_of(d));
        if (el[16] || er[16]) nclip++;
      end
      run_stream(d, 6 * (f + 1) + 20);
      checks++;
      if (timed_out || got_l.size() != 5 || acc_c.size() != 5) begin
        errors++; $display("FAIL rand_count_d%0d: got %0d latches expected 5", d, got_l.size());
      end else begin
        for (int i = 0; i < 5; i++) begin
          el = model(src_l[i], rnd_of(d)); er = model(src_r[i], rnd_of(d));
          checks++;
          if (got_l[i] !== el[15:0] || got_r[i] !== er[15:0]) begin
            errors++; $display("FAIL rand_word_d%0d_%0d: in %h/%h got %h/%h expected %h/%h",
                               d, i, src_l[i], src_r[i], got_l[i], got_r[i], el[15:0], er[15:0]);
          end
          checks++;
          if (le_low[i] != lb_of(d) * 2 * bh_of(d)) begin
            errors++; $display("FAIL rand_le_low_d%0d_%0d: got %0d expected %0d", d, i, le_low[i], lb_of(d) * 2 * bh_of(d));
          end
        end
        checks++;
        if (end_c - acc_c[4] != f) begin
          errors++; $display("FAIL rand_latency_d%0d: got %0d expected %0d", d, end_c - acc_c[4], f);
        end
      end
      checks++; if (clip_c.size() != nclip) begin errors++; $display("FAIL rand_clip_d%0d: got %0d expected %0d", d, clip_c.size(), nclip); end
      checks++; if (viol != 0) begin errors++; $display("FAIL rand_timing_d%0d: got %0d violations expected 0", d, viol); end
    end
  endtask

  initial begin
    valid = '0;
    for (int d = 0; d < N; d++) begin
      in_l[d] = '0; in_r[d] = '0;
    end
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_reset_mid_shift();
    test_fast();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
